// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// Module   : free_list
// Purpose  : Circular FIFO of free physical register indices, refilled by the
//            retirement RAT and drained by rename; flush restores it to full.
// Revision : 1.0 - initial release
// ============================================================================
module free_list #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_DEPTH = 32,
    parameter int PRF_IDX   = $clog2(PRF_DEPTH)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        rrf_valid,
    input  logic [PRF_IDX-1:0]                          rrf_stale_idx,
    input  logic                                        dq_ready,
    output logic                                        dq_valid,
    output logic [PRF_IDX-1:0]                          dq_idx,
    input  logic                                        flush,
    output logic [$clog2(PRF_DEPTH-ARF_DEPTH+1)-1:0]    free_count
);

    localparam int FL_DEPTH = PRF_DEPTH - ARF_DEPTH;
    localparam int C_IDX_W  = $clog2(FL_DEPTH);
    localparam int C_PTR_W  = C_IDX_W + 1;
    localparam int C_CNT_W  = $clog2(FL_DEPTH + 1);

    logic [PRF_IDX-1:0] r_mem [FL_DEPTH];
    logic [C_PTR_W-1:0] r_head;
    logic [C_PTR_W-1:0] r_tail;

    logic [C_IDX_W-1:0] w_head_idx;
    logic [C_IDX_W-1:0] w_tail_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_deq;
    logic               w_enq;
    logic [C_PTR_W-1:0] w_tail_next;
    logic [C_PTR_W-1:0] w_head_next;
    logic [C_CNT_W-1:0] w_count;

    // Index wraps at FL_DEPTH-1 and toggles the wrap bit, so depths need not be powers of two.
    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        if (p[C_IDX_W-1:0] == C_IDX_W'(FL_DEPTH - 1)) begin
            ptr_inc = {~p[C_PTR_W-1], {C_IDX_W{1'b0}}};
        end else begin
            ptr_inc = p + C_PTR_W'(1);
        end
    endfunction

    assign w_head_idx = r_head[C_IDX_W-1:0];
    assign w_tail_idx = r_tail[C_IDX_W-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[C_PTR_W-1] != r_tail[C_PTR_W-1]);

    assign w_deq = !w_empty && dq_ready && !flush;
    // A full list still accepts a write when the head is leaving on the same edge.
    assign w_enq = rrf_valid && (!w_full || w_deq);

    always_comb begin
        w_tail_next = r_tail;
        if (w_enq) begin
            w_tail_next = ptr_inc(r_tail);
        end
    end

    always_comb begin
        w_head_next = r_head;
        if (flush) begin
            w_head_next = {~w_tail_next[C_PTR_W-1], w_tail_next[C_IDX_W-1:0]};
        end else if (w_deq) begin
            w_head_next = ptr_inc(r_head);
        end
    end

    always_comb begin
        if (r_head[C_PTR_W-1] == r_tail[C_PTR_W-1]) begin
            w_count = C_CNT_W'(w_tail_idx) - C_CNT_W'(w_head_idx);
        end else begin
            w_count = C_CNT_W'(FL_DEPTH) + C_CNT_W'(w_tail_idx) - C_CNT_W'(w_head_idx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= {1'b1, {C_IDX_W{1'b0}}};
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
        end
    end

    // Reset contents mirror the RAT identity map: arch i owns phys i, the rest are free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_mem[i] <= PRF_IDX'(ARF_DEPTH + i);
            end
        end else if (w_enq) begin
            r_mem[w_tail_idx] <= rrf_stale_idx;
        end
    end

    assign dq_valid   = !w_empty;
    assign dq_idx     = r_mem[w_head_idx];
    assign free_count = w_count;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(rrf_valid && w_full && !w_deq));

    a_no_phys_zero: assert property (@(posedge clk) disable iff (!rst)
        !(rrf_valid && (rrf_stale_idx == '0)));

endmodule
`default_nettype wire
